// File: rtl/next_pc_predictor_pkg.sv
// Shared types and constants for the fetch-side next-PC predictor:
// BTB entry layout and 2-bit PHT counter encodings.
package next_pc_predictor_pkg;

    localparam int unsigned PKG_XLEN     = 32;
    localparam int unsigned PKG_IDX_BITS = 5;
    localparam int unsigned PKG_TAG_BITS = PKG_XLEN - PKG_IDX_BITS - 2;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam ctr_e RESET_CTR = WNT;

    typedef struct packed {
        logic                    valid;
        logic [PKG_TAG_BITS-1:0] tag;
        logic [PKG_XLEN-1:0]     target;
        logic                    is_jump;
    } btb_entry_t;

    function automatic logic ctr_taken(input ctr_e c);
        return c[1];
    endfunction

endpackage

// File: rtl/next_pc_predictor_sat_counter2.sv
// 2-bit saturating up/down counter used on the PHT training path.
module sat_counter2
    import next_pc_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic inc_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            SNT:     ctr_o = inc_i ? WNT : SNT;
            WNT:     ctr_o = inc_i ? WT  : SNT;
            WT:      ctr_o = inc_i ? ST  : WNT;
            ST:      ctr_o = inc_i ? ST  : WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC generator: direct-mapped BTB plus gshare PHT with a speculative
// global history register, trained from EX-stage resolution.
module next_pc_predictor
    import next_pc_predictor_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IDX_BITS  = 5,
    parameter int unsigned HIST_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      fetch_pc,
    input  logic                 fetch_en,
    output logic [XLEN-1:0]      pred_next_pc,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_bhr,
    input  logic                 upd_valid,
    input  logic [XLEN-1:0]      upd_pc,
    input  logic                 upd_is_branch,
    input  logic                 upd_is_jump,
    input  logic                 upd_taken,
    input  logic [XLEN-1:0]      upd_target,
    input  logic [HIST_BITS-1:0] upd_bhr,
    input  logic                 upd_mispredict
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    btb_entry_t           btb_q [ENTRIES];
    ctr_e                 pht_q [ENTRIES];
    logic [HIST_BITS-1:0] bhr_q, bhr_d;

    logic [IDX_BITS-1:0]  fetch_idx, fetch_gidx;
    logic [IDX_BITS-1:0]  upd_idx, upd_gidx;
    btb_entry_t           fetch_entry;
    logic                 fetch_hit;

    logic                 btb_we, pht_we;
    btb_entry_t           btb_wdata;
    ctr_e                 pht_wdata;
    logic                 unused_upd_pc_lsbs;

    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    // Lookup: purely combinational against the registered tables.
    always_comb begin
        fetch_idx    = fetch_pc[IDX_BITS+1:2];
        fetch_entry  = btb_q[fetch_idx];
        fetch_hit    = fetch_entry.valid && (fetch_entry.tag == fetch_pc[XLEN-1:IDX_BITS+2]);
        fetch_gidx   = fetch_idx ^ bhr_q;
        pred_taken   = fetch_hit && (fetch_entry.is_jump || ctr_taken(pht_q[fetch_gidx]));
        pred_next_pc = pred_taken ? fetch_entry.target : fetch_pc + XLEN'(4);
        pred_bhr     = bhr_q;
    end

    // Mispredict recovery is applied last so it overrides the speculative shift.
    always_comb begin
        bhr_d = bhr_q;
        if (fetch_en && fetch_hit && !fetch_entry.is_jump)
            bhr_d = {bhr_q[HIST_BITS-2:0], pred_taken};
        if (upd_valid && upd_mispredict)
            bhr_d = upd_is_branch ? {upd_bhr[HIST_BITS-2:0], upd_taken} : upd_bhr;
    end

    always_comb begin
        upd_idx           = upd_pc[IDX_BITS+1:2];
        upd_gidx          = upd_idx ^ upd_bhr;
        pht_we            = upd_valid && upd_is_branch;
        btb_we            = upd_valid && (upd_is_jump || (upd_is_branch && upd_taken));
        btb_wdata         = '0;
        btb_wdata.valid   = 1'b1;
        btb_wdata.tag     = upd_pc[XLEN-1:IDX_BITS+2];
        btb_wdata.target  = upd_target;
        btb_wdata.is_jump = upd_is_jump;
    end

    sat_counter2 u_pht_ctr (
        .ctr_i (pht_q[upd_gidx]),
        .inc_i (upd_taken),
        .ctr_o (pht_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
                pht_q[i] <= RESET_CTR;
            end
            bhr_q <= '0;
        end else begin
            bhr_q <= bhr_d;
            if (btb_we)
                btb_q[upd_idx] <= btb_wdata;
            if (pht_we)
                pht_q[upd_gidx] <= pht_wdata;
        end
    end

endmodule
